// File: rtl/pll_reconfig_pkg.sv
// -----------------------------------------------------------------------------
// pll_reconfig_pkg
// Shared definitions for the multi-PLL scan-chain reconfiguration engine:
// controller state encoding, register map addresses, CTRL bit positions and
// helpers that size the image register from the scan-chain length.
// -----------------------------------------------------------------------------
package pll_reconfig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_UPDATE,
        ST_WAIT,
        ST_STROBE
    } state_e;

    localparam logic [3:0] ADDR_CTRL      = 4'd0;
    localparam logic [3:0] ADDR_DATA_BASE = 4'd1;

    localparam int CTRL_HOLD_LSB    = 0;
    localparam int CTRL_SEL_LSB     = 8;
    localparam int CTRL_START_BIT   = 16;
    localparam int CTRL_ERR_BIT     = 29;
    localparam int CTRL_TIMEOUT_BIT = 30;
    localparam int CTRL_BUSY_BIT    = 31;

    // Number of 32-bit image words needed to hold the chain.
    function automatic int calc_data_regs(input int chain_bits);
        return (chain_bits + 31) / 32;
    endfunction

    // Unused low bits of the image (below the chain field).
    function automatic int calc_pad_bits(input int chain_bits);
        return 32 * calc_data_regs(chain_bits) - chain_bits;
    endfunction

endpackage

// File: rtl/pll_reconfig_multi_if.sv
// -----------------------------------------------------------------------------
// pll_reconfig_multi_if
// Avalon-MM slave bus of the reconfiguration engine.
//   address[3:0]    word address
//   writedata[31:0] write data, byteenable[3:0] byte lanes
//   write/read/chipselect strobes
//   readdata[31:0]  combinational read data
//   waitrequest_n   always 1 (zero wait states)
// -----------------------------------------------------------------------------
interface pll_reconfig_multi_if;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        write;
    logic        read;
    logic        chipselect;
    logic [31:0] readdata;
    logic        waitrequest_n;

    modport master (
        output address, writedata, byteenable, write, read, chipselect,
        input  readdata, waitrequest_n
    );

    modport slave (
        input  address, writedata, byteenable, write, read, chipselect,
        output readdata, waitrequest_n
    );
endinterface

// File: rtl/pll_scan_shifter.sv
// -----------------------------------------------------------------------------
// pll_scan_shifter
// Holds the scan-chain image. Software writes it as 32-bit words (address 1
// is the most significant word); during a shift the chain field
// image[W-1:PAD] moves right one bit per cycle and image[PAD] is the serial
// output.
//   wr_en_i/addr_i/wr_data_i/wr_be_i  word write port (caller gates on BUSY)
//   shift_i     advance the chain one bit
//   rd_data_o   word readback (0 unless readback is built in)
//   scan_bit_o  current serial bit, image[PAD]
// Build option PLL_RECONFIG_READBACK_EN: the field rotates (image intact
// after an update) and words read back; otherwise zeros shift in and reads
// return 0.
// -----------------------------------------------------------------------------
module pll_scan_shifter
    import pll_reconfig_pkg::*;
#(
    parameter int CHAIN_BITS = 144
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wr_en_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_be_i,
    input  logic        shift_i,
    output logic [31:0] rd_data_o,
    output logic        scan_bit_o
);

    localparam int DATA_REGS = calc_data_regs(CHAIN_BITS);
    localparam int W         = 32 * DATA_REGS;
    localparam int PAD       = calc_pad_bits(CHAIN_BITS);

    logic [W-1:0]          image_q, image_d;
    logic [CHAIN_BITS-1:0] field;
    logic                  feed_bit;

`ifdef PLL_RECONFIG_READBACK_EN
    assign feed_bit = image_q[PAD];
`else
    assign feed_bit = 1'b0;
`endif

    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        image_d = image_q;
        field   = image_q[W-1:PAD];
        if (shift_i) begin
            field                 = field >> 1;
            field[CHAIN_BITS-1]   = feed_bit;
            image_d[W-1:PAD]      = field;
        end else if (wr_en_i) begin
            for (int k = 0; k < DATA_REGS; k++) begin
                if (addr_i == ADDR_DATA_BASE + 4'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_be_i[b]) begin
                            image_d[W - 32*(k+1) + 8*b +: 8] = wr_data_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // NOTE: the image is a register file but is still reset, so a fresh start after reset shifts a known all-zero chain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            image_q <= '0;
        end else begin
            image_q <= image_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
`ifdef PLL_RECONFIG_READBACK_EN
        for (int k = 0; k < DATA_REGS; k++) begin
            if (addr_i == ADDR_DATA_BASE + 4'(k)) begin
                rd_data_o = image_q[W - 32*(k+1) +: 32];
            end
        end
`endif
    end

    assign scan_bit_o = image_q[PAD];

endmodule

// File: rtl/pll_reconfig_multi.sv
// -----------------------------------------------------------------------------
// pll_reconfig_multi
// Avalon-MM controlled scan-chain reconfiguration engine for up to 8 PLLs
// sharing one scan clock and data line. Software loads the image, writes
// CTRL with sel and start; the engine shifts CHAIN_BITS bits, pulses
// configupdate, waits for scandone (bounded by TIMEOUT_CYCLES) and strobes
// areset of the target PLL.
// Ports:
//   clk_i, rst_n_i    clock / async active-low reset
//   avalon_s          Avalon-MM slave (pll_reconfig_multi_if.slave)
//   areset[N]         hold_reset | one-cycle post-update strobe
//   scanclk           = clk_i
//   scanclkena[N]     high on the target PLL during the shift
//   configupdate[N]   one-cycle update pulse on the target PLL
//   scandata          shared serial data (0 outside the shift)
//   scandone[N]       per-PLL done inputs
// Build option PLL_RECONFIG_READBACK_EN: see pll_scan_shifter.
// -----------------------------------------------------------------------------
module pll_reconfig_multi
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_PLL        = 2,
    parameter int CHAIN_BITS     = 144,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    pll_reconfig_multi_if.slave  avalon_s,
    output logic [NUM_PLL-1:0]   areset,
    output logic                 scanclk,
    output logic [NUM_PLL-1:0]   scanclkena,
    output logic [NUM_PLL-1:0]   configupdate,
    output logic                 scandata,
    input  logic [NUM_PLL-1:0]   scandone
);

    localparam logic [3:0] NUM_PLL_W = 4'(NUM_PLL);

    state_e             state_q, state_d;
    logic [NUM_PLL-1:0] hold_q, hold_d;
    logic [2:0]         sel_q, sel_d, tgt_q, tgt_d;
    logic               err_q, err_d, timeout_q, timeout_d;
    logic [7:0]         bit_cnt_q, bit_cnt_d, tmo_cnt_q, tmo_cnt_d;
    logic               done_q, done_dly_q, edge_q;
    logic [NUM_PLL-1:0] tgt_oh;
    logic               wr_ctrl, start_req, busy, shift_en, scan_bit;
    logic [2:0]         start_sel;
    logic [31:0]        ctrl_rdata, data_rdata;

    assign busy    = (state_q != ST_IDLE);
    assign wr_ctrl = avalon_s.chipselect & avalon_s.write & (avalon_s.address == ADDR_CTRL);
    // Start is a write pulse acted on at the write edge; it is never stored,
    // so it reads back as 0 on the following cycle.
    assign start_req = wr_ctrl & avalon_s.byteenable[2] & avalon_s.writedata[CTRL_START_BIT];
    // A start written together with sel uses the new sel.
    assign start_sel = avalon_s.byteenable[1] ? avalon_s.writedata[CTRL_SEL_LSB +: 3] : sel_q;

    always_comb begin
        tgt_oh = '0;
        for (int i = 0; i < NUM_PLL; i++) begin
            tgt_oh[i] = (tgt_q == 3'(i));
        end
    end

    always_comb begin
        hold_d = hold_q;
        sel_d  = sel_q;
        if (wr_ctrl) begin
            if (avalon_s.byteenable[0]) hold_d = avalon_s.writedata[CTRL_HOLD_LSB +: NUM_PLL];
            if (avalon_s.byteenable[1]) sel_d  = avalon_s.writedata[CTRL_SEL_LSB +: 3];
        end
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        shift_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if ({1'b0, start_sel} < NUM_PLL_W) begin
                        err_d     = 1'b0;
                        timeout_d = 1'b0;
                        tgt_d     = start_sel;
                        bit_cnt_d = 8'(CHAIN_BITS - 1);
                        state_d   = ST_SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt_q == 8'd0) state_d = ST_UPDATE;
                else                   bit_cnt_d = bit_cnt_q - 8'd1;
            end
            ST_UPDATE: begin
                tmo_cnt_d = 8'(TIMEOUT_CYCLES);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // The scandone edge has priority over the counter expiring.
                if (edge_q) begin
                    state_d = ST_STROBE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 8'd1;
                    if (tmo_cnt_q == 8'd1) begin
                        timeout_d = 1'b1;
                        state_d   = ST_STROBE;
                    end
                end
            end
            ST_STROBE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            sel_q      <= '0;
            tgt_q      <= '0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            done_q     <= 1'b0;
            done_dly_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            sel_q      <= sel_d;
            tgt_q      <= tgt_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            // scandone of the target: register, then a registered rising edge.
            done_q     <= |(scandone & tgt_oh);
            done_dly_q <= done_q;
            edge_q     <= done_q & ~done_dly_q;
        end
    end

    pll_scan_shifter #(.CHAIN_BITS(CHAIN_BITS)) u_shifter (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_en_i    (avalon_s.chipselect & avalon_s.write & ~busy),
        .addr_i     (avalon_s.address),
        .wr_data_i  (avalon_s.writedata),
        .wr_be_i    (avalon_s.byteenable),
        .shift_i    (shift_en),
        .rd_data_o  (data_rdata),
        .scan_bit_o (scan_bit)
    );

    assign ctrl_rdata = {busy, timeout_q, err_q, 18'd0, sel_q, 8'(hold_q)};

    assign avalon_s.readdata = (avalon_s.chipselect & avalon_s.read)
                             ? ((avalon_s.address == ADDR_CTRL) ? ctrl_rdata : data_rdata)
                             : '0;
    assign avalon_s.waitrequest_n = 1'b1;

    assign scanclk      = clk_i;
    assign scanclkena   = (state_q == ST_SHIFT)  ? tgt_oh : '0;
    assign configupdate = (state_q == ST_UPDATE) ? tgt_oh : '0;
    assign areset       = hold_q | ((state_q == ST_STROBE) ? tgt_oh : '0);
    assign scandata     = (state_q == ST_SHIFT) & scan_bit;

endmodule

// File: tb/tb_pll_reconfig_multi.sv
// -----------------------------------------------------------------------------
// tb_pll_reconfig_multi
// Self-checking bench for pll_reconfig_multi with default parameters.
// Random images and scandone timings are checked against a cycle-level
// reference of the transaction (shift window, update cycle, strobe cycle,
// timeout flag) built from the register map and timing rules.
// -----------------------------------------------------------------------------
module tb_pll_reconfig_multi;

    localparam int NUM_PLL = 2;
    localparam int CHAIN   = 144;
    localparam int TMO     = 255;
    localparam int REGS    = (CHAIN + 31) / 32;
    localparam int W       = 32 * REGS;
    localparam int PAD     = W - CHAIN;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_PLL-1:0] scandone = '0;
    logic [NUM_PLL-1:0] areset, scanclkena, configupdate;
    logic               scanclk, scandata;

    pll_reconfig_multi_if bus();

    pll_reconfig_multi #(
        .NUM_PLL(NUM_PLL), .CHAIN_BITS(CHAIN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .avalon_s     (bus),
        .areset       (areset),
        .scanclk      (scanclk),
        .scanclkena   (scanclkena),
        .configupdate (configupdate),
        .scandata     (scandata),
        .scandone     (scandone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [W-1:0] exp_img  = '0;
    logic [2:0]   exp_sel  = '0;
    logic [7:0]   exp_hold = '0;
    logic         exp_err  = 1'b0;
    logic         exp_to   = 1'b0;

    // ---------------- output monitor ----------------
    bit               mon_en = 1'b0;
    int               ena_cnt[NUM_PLL];
    int               upd_cnt[NUM_PLL];
    int               rst_cnt[NUM_PLL];
    int               sd_cnt, first_shift, upd_cyc, strobe_cyc, scan_idx;
    bit               upd_seen, strobe_seen;
    logic [CHAIN-1:0] scan_vec;

    task automatic mon_clear();
        for (int i = 0; i < NUM_PLL; i++) begin
            ena_cnt[i] = 0; upd_cnt[i] = 0; rst_cnt[i] = 0;
        end
        sd_cnt = 0; first_shift = -1; upd_cyc = -1; strobe_cyc = -1; scan_idx = 0;
        upd_seen = 1'b0; strobe_seen = 1'b0; scan_vec = '0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NUM_PLL; i++) begin
                if (scanclkena[i]) ena_cnt[i]++;
                if (configupdate[i]) begin
                    upd_cnt[i]++; upd_cyc = cyc; upd_seen = 1'b1;
                end
                if (areset[i]) begin
                    rst_cnt[i]++; strobe_cyc = cyc; strobe_seen = 1'b1;
                end
            end
            if (scandata) sd_cnt++;
            if (|scanclkena) begin
                if (first_shift < 0) first_shift = cyc;
                if (scan_idx < CHAIN) scan_vec[scan_idx] = scandata;
                scan_idx++;
            end
        end
    end

    // ---------------- bus helpers (called at posedge+1) ----------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.chipselect = 1'b1; bus.write = 1'b1;
        bus.address = a; bus.writedata = d; bus.byteenable = be;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.byteenable = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(negedge clk);
        d = bus.readdata;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.read = 1'b0;
    endtask

    task automatic check_ctrl(input string tag, input logic busy);
        logic [31:0] d;
        bus_read(4'd0, d);
        check(tag, d, {busy, exp_to, exp_err, 18'd0, exp_sel, exp_hold});
    endtask

    task automatic check_readback(input string tag);
        logic [31:0] d, e, m;
        for (int k = 0; k < REGS; k++) begin
            bus_read(4'(k + 1), d);
`ifdef PLL_RECONFIG_READBACK_EN
            e = exp_img[W - 32*(k+1) +: 32];
`else
            e = '0;
`endif
            // Bits below the chain field are don't-care.
            m = (k == REGS - 1) ? ~((32'h1 << PAD) - 32'h1) : 32'hFFFF_FFFF;
            check(tag, d & m, e & m);
        end
    endtask

    task automatic load_image();
        logic [31:0] w;
        for (int k = 0; k < REGS; k++) begin
            w = $urandom;
            bus_write(4'(k + 1), w, 4'hF);
            exp_img[W - 32*(k+1) +: 32] = w;
        end
    endtask

    // One full reconfiguration. delay < 0: scandone never rises.
    task automatic run_op(input int sel, input int delay, input bit poke);
        int          start_cyc, rise_cyc, upd_exp, strobe_exp;
        logic        to_exp;
        logic [31:0] d;
        load_image();
        mon_clear();
        mon_en = 1'b1;
        bus_write(4'd0, (32'(sel) << 8) | 32'h0001_0000, 4'b0110);
        exp_sel   = 3'(sel);
        start_cyc = cyc;   // first cycle after the start edge
        if (poke) begin
            repeat (5) @(posedge clk);
            #1;
            bus_read(4'd0, d);
            check("busy_in_shift", d[31], 1'b1);
            bus_write(4'd2, 32'hDEAD_BEEF, 4'hF);        // ignored while busy
            bus_write(4'd0, 32'h0001_0000, 4'b0100);     // start ignored while busy
        end
        for (int i = 0; i < CHAIN + 40 && !upd_seen; i++) begin
            @(posedge clk); #1;
        end
        check("update_seen", upd_seen, 1'b1);
        rise_cyc = -1;
        if (delay >= 0) begin
            repeat (delay) begin
                @(posedge clk); #1;
            end
            scandone[sel] = 1'b1;
            rise_cyc = cyc;
        end
        for (int i = 0; i < TMO + 40 && !strobe_seen; i++) begin
            @(posedge clk); #1;
        end
        check("strobe_seen", strobe_seen, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        scandone = '0;
        mon_en   = 1'b0;

        // Reference timing: SHIFT start..start+CHAIN-1, UPDATE start+CHAIN,
        // WAIT for TMO cycles; an edge is acted on 2 cycles after the rise.
        upd_exp = start_cyc + CHAIN;
        if (delay >= 0 && rise_cyc + 2 <= upd_exp + TMO) begin
            strobe_exp = rise_cyc + 3;
            to_exp     = 1'b0;
        end else begin
            strobe_exp = upd_exp + TMO + 1;
            to_exp     = 1'b1;
        end

        check("first_shift_cycle", first_shift, start_cyc);
        check("scanclkena_cycles", ena_cnt[sel], CHAIN);
        check("scandata_sequence", scan_vec, exp_img[W-1:PAD]);
        check("configupdate_count", upd_cnt[sel], 1);
        check("configupdate_cycle", upd_cyc, upd_exp);
        check("areset_count", rst_cnt[sel], 1);
        check("areset_cycle", strobe_cyc, strobe_exp);
        for (int i = 0; i < NUM_PLL; i++) begin
            if (i != sel) check("other_pll_quiet", ena_cnt[i] + upd_cnt[i] + rst_cnt[i], 0);
        end
`ifndef PLL_RECONFIG_READBACK_EN
        exp_img[W-1:PAD] = '0;
`endif
        exp_to  = to_exp;
        exp_err = 1'b0;
        check_ctrl("ctrl_after_op", 1'b0);
        check_readback("image_readback");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = '0; bus.writedata = '0; bus.byteenable = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {areset, scanclkena, configupdate, scandata}, '0);
        check("waitrequest_n", bus.waitrequest_n, 1'b1);
        check("scanclk_high", scanclk, 1'b1);
        @(negedge clk);
        check("scanclk_low", scanclk, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_ctrl("ctrl_after_reset", 1'b0);

        // hold_reset and byteenable.
        bus_write(4'd0, 32'h0000_00FF, 4'b0001);
        exp_hold = 8'h03;
        check("areset_hold", areset, 2'b11);
        check_ctrl("ctrl_hold", 1'b0);
        bus_write(4'd0, 32'hFFFF_FFFF, 4'b0000);
        check_ctrl("ctrl_no_lanes", 1'b0);
        bus_write(4'd0, 32'h0, 4'b0001);
        exp_hold = 8'h00;
        check("areset_released", areset, 2'b00);
        bus_read(4'd9, d);
        check("unmapped_read", d, 32'h0);

        // Directed: sel=1, scandone 20 cycles after update, writes during SHIFT.
        run_op(1, 20, 1'b1);
        // scandone never rises: timeout.
        run_op(0, -1, 1'b0);

        // Out-of-range sel: ERR set, nothing moves, TIMEOUT kept.
        mon_clear();
        mon_en = 1'b1;
        bus_write(4'd0, 32'h0001_0300, 4'b0110);
        exp_sel = 3'd3;
        exp_err = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("err_no_activity", ena_cnt[0] + ena_cnt[1] + upd_cnt[0] + upd_cnt[1]
                                 + rst_cnt[0] + rst_cnt[1] + sd_cnt, 0);
        check_ctrl("ctrl_err", 1'b0);
        bus.chipselect = 1'b1; bus.address = 4'd0;
        @(negedge clk);
        check("readdata_gated", bus.readdata, 32'h0);
        @(posedge clk); #1;
        bus.chipselect = 1'b0;

        // Edge coinciding with the last WAIT cycle wins; one cycle later loses.
        run_op(1, TMO - 3, 1'b0);
        run_op(0, TMO - 2, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 6; n++) begin
            int s, dl;
            s  = int'($urandom_range(0, NUM_PLL - 1));
            dl = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 200));
            run_op(s, dl, 1'b0);
        end

        // Reset in the middle of SHIFT.
        load_image();
        bus_write(4'd0, 32'h0001_0100, 4'b0110);
        repeat (50) @(posedge clk);
        #1;
        check("ena_before_reset", scanclkena, 2'b10);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {areset, scanclkena, configupdate, scandata}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_img = '0; exp_sel = '0; exp_hold = '0; exp_err = 1'b0; exp_to = 1'b0;
        @(posedge clk); #1;
        check_ctrl("ctrl_after_mid_reset", 1'b0);
        check_readback("image_after_reset");
        run_op(1, 30, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
